// File: rtl/div_share_pkg.sv
// rtl/div_share_pkg.sv - shared types and helpers for the divider share arbiter
// Contents: arbiter state enum, result status struct, id width helper.
package div_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic zerodiv;
    logic overflow;
    logic timeout;
  } div_status_t;

  // Width of a requester index; never below one bit so ports stay legal.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority picker for the divider share arbiter
// Ports:
//   valid  in   N   request vector
//   ptr    in   IW  highest-priority index for this pick
//   found  out  1   at least one request is valid
//   index  out  IW  first valid index at or after ptr, wrapping modulo N
module rr_pick
  import div_share_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [2*N-2:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW-1:0]  offset;
  logic [IW:0]    sum;

  always_comb begin
    // rotated[k] corresponds to valid[(ptr + k) mod N]
    doubled = {valid[N-2:0], valid};
    rotated = doubled[ptr +: N];
    found   = 1'b0;
    offset  = '0;
    // Descending scan so the lowest set offset wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found  = 1'b1;
        offset = k[IW-1:0];
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= N_EXT) begin
      sum = sum - N_EXT;
    end
    index = sum[IW-1:0];
  end

endmodule

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin scheduler sharing one iterative divider among NUM_REQ lanes
// Ports:
//   clk_in, rst_n_in                  clock, asynchronous active-low reset
//   req_valid_in/req_ready_out        per-lane job handshake (ready is one-hot, one cycle)
//   req_a_in/req_b_in                 packed per-lane dividend/divisor, lane i = [i*WIDTH +: WIDTH]
//   resp_valid_out/resp_ready_in      per-lane result handshake (valid is one-hot)
//   resp_q_out, resp_*_out            shared result bus and status flags
//   div_start_out, div_a_out/b_out    divider launch pulse and held operands
//   div_done_in, div_valid_in, div_zerodiv_in, div_overflow_in, div_q_in   divider result
//   busy_out, grant_id_out            activity flag and current/last owner
// Optional feature: define DIV_SHARE_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES.
module div_share_arbiter
  import div_share_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  WIDTH          = 16,
  parameter int  FRAC_BITS      = 14,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int ID_W           = id_w(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_in,
  output logic [NUM_REQ-1:0]       resp_valid_out,
  input  logic [NUM_REQ-1:0]       resp_ready_in,
  output logic [WIDTH-1:0]         resp_q_out,
  output logic                     resp_zerodiv_out,
  output logic                     resp_overflow_out,
  output logic                     resp_timeout_out,
  output logic                     div_start_out,
  output logic [WIDTH-1:0]         div_a_out,
  output logic [WIDTH-1:0]         div_b_out,
  input  logic                     div_done_in,
  input  logic                     div_valid_in,
  input  logic                     div_zerodiv_in,
  input  logic                     div_overflow_in,
  input  logic [WIDTH-1:0]         div_q_in,
  output logic                     busy_out,
  output logic [ID_W-1:0]          grant_id_out
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t           state, state_next;
  logic             armed;
  logic             grant;
  logic             pick_found;
  logic [ID_W-1:0]  pick_index;
  logic [ID_W-1:0]  owner;
  logic [ID_W-1:0]  rr_ptr;
  logic [WIDTH-1:0] a_reg, b_reg, q_reg;
  div_status_t      status;
  logic             timeout_hit;
  logic [WIDTH-1:0] lane_a [NUM_REQ];
  logic [WIDTH-1:0] lane_b [NUM_REQ];

  // Fraction position belongs to the divider; the arbiter only moves bits.
  logic unused_cfg;
  assign unused_cfg = ^{FRAC_BITS, TIMEOUT_CYCLES};

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_a[i] = req_a_in[i*WIDTH +: WIDTH];
      lane_b[i] = req_b_in[i*WIDTH +: WIDTH];
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .valid (req_valid_in),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_index)
  );

  // armed stays low for the first cycle after reset so that no ready can
  // appear while rst_n_in is still asserted.
  assign grant = (state == IDLE) && armed && pick_found;

`ifdef DIV_SHARE_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // WAIT starts one cycle after the start pulse, so firing at count
  // TIMEOUT_CYCLES-2 lands RESP exactly TIMEOUT_CYCLES after start.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  assign timeout_hit = (state == WAIT) && (wd_cnt == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a done seen in ISSUE is ignored because ISSUE never samples it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (div_done_in || timeout_hit) state_next = RESP;
      RESP:    if (resp_ready_in[owner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_out  = '0;
    resp_valid_out = '0;
    div_start_out  = 1'b0;
    busy_out       = (state != IDLE);
    case (state)
      IDLE:    if (grant) req_ready_out[pick_index] = 1'b1;
      ISSUE:   div_start_out = 1'b1;
      RESP:    resp_valid_out[owner] = 1'b1;
      default: ;
    endcase
  end

  // Job and result registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      armed  <= 1'b0;
      owner  <= '0;
      rr_ptr <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      q_reg  <= '0;
      status <= '0;
    end else begin
      armed <= 1'b1;
      if (grant) begin
        owner <= pick_index;
        a_reg <= lane_a[pick_index];
        b_reg <= lane_b[pick_index];
      end
      if (state == WAIT) begin
        if (div_done_in) begin
          q_reg  <= div_valid_in ? div_q_in : '0;
          status <= '{zerodiv: div_zerodiv_in, overflow: div_overflow_in, timeout: 1'b0};
        end else if (timeout_hit) begin
          q_reg  <= '0;
          status <= '{zerodiv: 1'b0, overflow: 1'b0, timeout: 1'b1};
        end
      end
      if ((state == RESP) && resp_ready_in[owner]) begin
        rr_ptr <= (owner == LAST_ID) ? '0 : owner + ID_W'(1);
      end
    end
  end

  assign resp_q_out        = q_reg;
  assign resp_zerodiv_out  = status.zerodiv;
  assign resp_overflow_out = status.overflow;
  assign resp_timeout_out  = status.timeout;
  assign div_a_out         = a_reg;
  assign div_b_out         = b_reg;
  assign grant_id_out      = owner;

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - directed self-checking bench for div_share_arbiter
module tb_div_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int FB = 14;
  localparam int TC = 64;
  localparam int D  = 31;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   resp_q, div_a, div_b, div_q;
  logic           resp_zd, resp_ov, resp_to;
  logic           div_start, div_done, div_valid, div_zd, div_ov;
  logic           busy;
  logic [1:0]     grant_id;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int prev_acc = 0;

  logic [W-1:0] lane_a [N];
  logic [W-1:0] lane_b [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_share_arbiter #(
    .NUM_REQ        (N),
    .WIDTH          (W),
    .FRAC_BITS      (FB),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .req_valid_in      (req_valid),
    .req_ready_out     (req_ready),
    .req_a_in          (req_a),
    .req_b_in          (req_b),
    .resp_valid_out    (resp_valid),
    .resp_ready_in     (resp_ready),
    .resp_q_out        (resp_q),
    .resp_zerodiv_out  (resp_zd),
    .resp_overflow_out (resp_ov),
    .resp_timeout_out  (resp_to),
    .div_start_out     (div_start),
    .div_a_out         (div_a),
    .div_b_out         (div_b),
    .div_done_in       (div_done),
    .div_valid_in      (div_valid),
    .div_zerodiv_in    (div_zd),
    .div_overflow_in   (div_ov),
    .div_q_in          (div_q),
    .busy_out          (busy),
    .grant_id_out      (grant_id)
  );

  // Divider model: Q(W-FB).FB signed divide, done D cycles after start.
  function automatic logic [18:0] model_div(input logic [15:0] a, input logic [15:0] b);
    longint n;
    longint r;
    if (b == 16'h0000) return {3'b010, 16'h0000};
    n = longint'($signed(a)) * 64'sd16384;
    r = n / longint'($signed(b));
    if (r > 64'sd32767 || r < -64'sd32768) return {3'b001, 16'h0000};
    return {3'b100, r[15:0]};
  endfunction

  logic         mdl_busy;
  logic         mdl_hang;
  int           mdl_cnt;
  logic [W-1:0] mdl_a, mdl_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy  <= 1'b0;
      mdl_cnt   <= 0;
      mdl_a     <= '0;
      mdl_b     <= '0;
      div_done  <= 1'b0;
      div_valid <= 1'b0;
      div_zd    <= 1'b0;
      div_ov    <= 1'b0;
      div_q     <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= 1;
        mdl_a    <= div_a;
        mdl_b    <= div_b;
      end else if (mdl_busy && !mdl_hang) begin
        if (mdl_cnt == D - 1) begin
          mdl_busy <= 1'b0;
          div_done <= 1'b1;
          {div_valid, div_zd, div_ov, div_q} <= model_div(mdl_a, mdl_b);
        end else begin
          mdl_cnt <= mdl_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int l, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[l*W +: W] = a;
    req_b[l*W +: W] = b;
    lane_a[l]       = a;
    lane_b[l]       = b;
    req_valid[l]    = 1'b1;
  endtask

  task automatic wait_grant(input int l);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", 64'(n < 200), 64'd1);
    check("grant_onehot", 64'(req_ready), 64'd1 << l);
    t_acc = cyc;
    @(posedge clk);
    #1 req_valid[l] = 1'b0;
    @(negedge clk);
    check("start_pulse", 64'(div_start), 64'd1);
    check("div_a", 64'(div_a), 64'(lane_a[l]));
    check("div_b", 64'(div_b), 64'(lane_b[l]));
    check("grant_id", 64'(grant_id), 64'(l));
    check("busy_job", 64'(busy), 64'd1);
  endtask

  task automatic wait_resp(input int l, input logic [W-1:0] q, input logic zd, input logic ov,
                           input logic to, input int lat, input int hold);
    int n;
    logic [W-1:0] q_seen;
    n = 0;
    while (resp_valid == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("resp_seen", 64'(n < 300), 64'd1);
    check("resp_latency", 64'(cyc - t_acc), 64'(lat));
    check("resp_onehot", 64'(resp_valid), 64'd1 << l);
    check("resp_q", 64'(resp_q), 64'(q));
    check("resp_flags", 64'({resp_zd, resp_ov, resp_to}), 64'({zd, ov, to}));
    q_seen = resp_q;
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1 << l);
      check("hold_q", 64'(resp_q), 64'(q_seen));
      check("hold_no_grant", 64'(req_ready), 64'd0);
      check("hold_no_start", 64'(div_start), 64'd0);
    end
    resp_ready[l] = 1'b1;
    @(posedge clk);
    #1 resp_ready[l] = 1'b0;
    check("idle_after_resp", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    mdl_hang   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({req_ready, resp_valid, resp_q, resp_zd, resp_ov, resp_to,
               div_start, div_a, div_b, busy, grant_id}), 64'd0);
    rst_n = 1'b1;

    // All lanes request together; lane 0 re-requests after its first grant.
    @(posedge clk);
    #1;
    issue(0, 16'h1000, 16'h2000);
    issue(1, 16'h0800, 16'h4000);
    issue(2, 16'hF000, 16'h2000);
    issue(3, 16'h1000, 16'hC000);
    wait_grant(0);
    issue(0, 16'h1000, 16'h2000);
    wait_resp(0, 16'h2000, 1'b0, 1'b0, 1'b0, D + 2, 0);
    prev_acc = t_acc;
    wait_grant(1);
    check("job_period_1", 64'(t_acc - prev_acc), 64'(D + 3));
    wait_resp(1, 16'h0800, 1'b0, 1'b0, 1'b0, D + 2, 0);
    prev_acc = t_acc;
    wait_grant(2);
    check("job_period_2", 64'(t_acc - prev_acc), 64'(D + 3));
    wait_resp(2, 16'hE000, 1'b0, 1'b0, 1'b0, D + 2, 0);
    wait_grant(3);
    wait_resp(3, 16'hF000, 1'b0, 1'b0, 1'b0, D + 2, 0);
    wait_grant(0);
    wait_resp(0, 16'h2000, 1'b0, 1'b0, 1'b0, D + 2, 0);

    // Single job on lane 2.
    issue(2, 16'h1000, 16'h2000);
    wait_grant(2);
    wait_resp(2, 16'h2000, 1'b0, 1'b0, 1'b0, D + 2, 0);

    // Backpressure on lane 0 while lane 1 (divide by zero) waits.
    issue(0, 16'h0800, 16'h4000);
    wait_grant(0);
    issue(1, 16'h1000, 16'h0000);
    wait_resp(0, 16'h0800, 1'b0, 1'b0, 1'b0, D + 2, 10);
    wait_grant(1);
    wait_resp(1, 16'h0000, 1'b1, 1'b0, 1'b0, D + 2, 0);

    // Overflow: -2.0 / 0.5.
    issue(2, 16'h8000, 16'h2000);
    wait_grant(2);
    wait_resp(2, 16'h0000, 1'b0, 1'b1, 1'b0, D + 2, 0);

    // Reset while lane 3 waits on the divider.
    issue(3, 16'h1000, 16'h2000);
    wait_grant(3);
    repeat (5) @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("reset_mid_wait",
          64'({req_ready, resp_valid, resp_q, resp_zd, resp_ov, resp_to,
               div_start, div_a, div_b, busy, grant_id}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("idle_after_reset", 64'(busy), 64'd0);
    issue(3, 16'h1000, 16'h4000);
    wait_grant(3);
    wait_resp(3, 16'h1000, 1'b0, 1'b0, 1'b0, D + 2, 0);

`ifdef DIV_SHARE_TIMEOUT_EN
    // Divider never completes: response must come from the watchdog.
    mdl_hang = 1'b1;
    issue(0, 16'h1000, 16'h2000);
    wait_grant(0);
    wait_resp(0, 16'h0000, 1'b0, 1'b0, 1'b1, TC + 1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
